// File: rtl/branch_resolver_pkg.sv
// Shared types, widths and decode constants for the branch resolver.
package branch_resolver_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned STATUS_W = 3;
    localparam int unsigned FCNT_W   = 4;

    // Bit positions inside the ALU compare-flag vector
    localparam int unsigned STATUS_EQ  = 0;
    localparam int unsigned STATUS_LT  = 1;
    localparam int unsigned STATUS_LTU = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    // jalr clears bit 0 of the computed address; branch/jal are pc-relative
    function automatic logic [XLEN-1:0] calc_target(
        input logic            jalr,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] imm,
        input logic [XLEN-1:0] rs1
    );
        logic [XLEN-1:0] sum;
        sum = jalr ? (rs1 + imm) : (pc + imm);
        return jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    endfunction

endpackage

// File: rtl/branch_resolver_cond.sv
// Branch condition decode: funct3 and compare flags to taken / illegal.
module branch_cond
    import branch_resolver_pkg::*;
(
    input  logic [F3_W-1:0]     funct3,
    input  logic [STATUS_W-1:0] status,
    output logic                taken_c,
    output logic                illegal_c
);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (funct3)
            F3_BEQ:  taken_c = status[STATUS_EQ];
            F3_BNE:  taken_c = !status[STATUS_EQ];
            F3_BLT:  taken_c = status[STATUS_LT];
            F3_BGE:  taken_c = !status[STATUS_LT];
            F3_BLTU: taken_c = status[STATUS_LTU];
            F3_BGEU: taken_c = !status[STATUS_LTU];
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage control-transfer resolver: decides redirects, drives the
// fetch redirect strobe, holds flush, and reports misaligned/illegal transfers.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                is_branch,
    input  logic                is_jal,
    input  logic                is_jalr,
    input  logic [F3_W-1:0]     funct3,
    input  logic [STATUS_W-1:0] status,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     rs1,
    output logic                redirect,
    output logic [XLEN-1:0]     target,
    output logic [XLEN-1:0]     link,
    output logic                flush,
    output logic                misalign,
    output logic                illegal,
    output logic [CNT_W-1:0]    taken_count
);

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                redirect_d, flush_d, misalign_d, illegal_d;
    logic [XLEN-1:0]     target_d, link_d;
    logic [CNT_W-1:0]    count_d;

    logic                accept;
    logic [1:0]          class_cnt;
    logic                class_ok;
    logic                cond_taken, cond_illegal;
    logic [XLEN-1:0]     tgt;

    branch_cond u_cond (
        .funct3    (funct3),
        .status    (status),
        .taken_c   (cond_taken),
        .illegal_c (cond_illegal)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign class_cnt = 2'(is_branch) + 2'(is_jal) + 2'(is_jalr);
    assign class_ok  = (class_cnt == 2'd1);
    assign tgt       = calc_target(is_jalr, pc, imm, rs1);

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= '0;
            redirect    <= 1'b0;
            flush       <= 1'b0;
            misalign    <= 1'b0;
            illegal     <= 1'b0;
            target      <= '0;
            link        <= '0;
            taken_count <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            redirect    <= redirect_d;
            flush       <= flush_d;
            misalign    <= misalign_d;
            illegal     <= illegal_d;
            target      <= target_d;
            link        <= link_d;
            taken_count <= count_d;
        end
    end

    // Next-state and next-output logic; flush is high exactly while not IDLE
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        redirect_d = 1'b0;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        illegal_d  = 1'b0;
        target_d   = target;
        link_d     = link;
        count_d    = taken_count;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!class_ok || (is_branch && cond_illegal)) begin
                        illegal_d = 1'b1;
                    end else begin
                        if (!is_branch) begin
                            link_d = pc + XLEN'(4);
                        end
                        if (!is_branch || cond_taken) begin
                            if (tgt[1]) begin
                                misalign_d = 1'b1;
                            end else begin
                                redirect_d = 1'b1;
                                flush_d    = 1'b1;
                                target_d   = tgt;
                                count_d    = taken_count + CNT_W'(1);
                                state_d    = ST_REDIRECT;
                            end
                        end
                    end
                end
            end
            ST_REDIRECT: begin
                state_d = ST_FLUSH;
                fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
                flush_d = 1'b1;
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d  = fcnt_q - FCNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
